// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: state codes, lamp
// patterns and the state-to-lamp mapping.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_ALL_RED_B   = 3'd5,
    ST_PED_WALK    = 3'd6,
    ST_FLASH       = 3'd7
  } tlc_state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {main_light, side_light, walk}; flash_on selects the lit half of the flash blink.
  function automatic logic [6:0] lamp_map(input logic [2:0] st, input logic flash_on);
    logic [6:0] l;
    case (st)
      3'd0:    l = {LAMP_GRN, LAMP_RED, 1'b0};
      3'd1:    l = {LAMP_YEL, LAMP_RED, 1'b0};
      3'd2:    l = {LAMP_RED, LAMP_RED, 1'b0};
      3'd3:    l = {LAMP_RED, LAMP_GRN, 1'b0};
      3'd4:    l = {LAMP_RED, LAMP_YEL, 1'b0};
      3'd5:    l = {LAMP_RED, LAMP_RED, 1'b0};
      3'd6:    l = {LAMP_RED, LAMP_RED, 1'b1};
      3'd7:    l = flash_on ? {LAMP_YEL, LAMP_YEL, 1'b0} : {LAMP_OFF, LAMP_OFF, 1'b0};
      default: l = {LAMP_RED, LAMP_RED, 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable phase down-counter advanced by the 1 Hz tick; it never counts
// below 1, so an unserviced expiry simply holds at 1.
module tlc_phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Phase counter: load on state entry, otherwise decrement on tick down to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_W'(RST_VAL);
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r > ONE)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count  = count_r;
  assign expire = tick && (count_r == ONE);

endmodule

// File: rtl/traffic_light_fsm.sv
// Four-way intersection controller with latched side-road and pedestrian demand.
// Define TLC_FLASH_EN to add the `flash` input and the blinking-yellow FLASH state.
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int MAIN_GREEN_S = 10,
  parameter int SIDE_GREEN_S = 6,
  parameter int YELLOW_S     = 3,
  parameter int ALL_RED_S    = 1,
  parameter int WALK_S       = 5,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             side_car,
  input  logic             ped_req,
`ifdef TLC_FLASH_EN
  input  logic             flash,
`endif
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic [2:0]       state_code,
  output logic [CNT_W-1:0] time_left
);

  localparam logic [2:0] S_MAIN_GREEN  = ST_MAIN_GREEN;
  localparam logic [2:0] S_MAIN_YELLOW = ST_MAIN_YELLOW;
  localparam logic [2:0] S_ALL_RED_A   = ST_ALL_RED_A;
  localparam logic [2:0] S_SIDE_GREEN  = ST_SIDE_GREEN;
  localparam logic [2:0] S_SIDE_YELLOW = ST_SIDE_YELLOW;
  localparam logic [2:0] S_ALL_RED_B   = ST_ALL_RED_B;
  localparam logic [2:0] S_PED_WALK    = ST_PED_WALK;
`ifdef TLC_FLASH_EN
  localparam logic [2:0] S_FLASH       = ST_FLASH;
`endif

  if (MAIN_GREEN_S < 1 || MAIN_GREEN_S >= (1 << CNT_W) ||
      SIDE_GREEN_S < 1 || SIDE_GREEN_S >= (1 << CNT_W) ||
      YELLOW_S     < 1 || YELLOW_S     >= (1 << CNT_W) ||
      ALL_RED_S    < 1 || ALL_RED_S    >= (1 << CNT_W) ||
      WALK_S       < 1 || WALK_S       >= (1 << CNT_W)) begin : g_bad_duration
    $error("traffic_light_fsm: every phase duration must lie in [1, 2**CNT_W)");
  end

  logic [2:0]       state_r, state_base_s, state_nx_s;
  logic             side_pend_r, ped_pend_r;
  logic             enter_sg_s, enter_pw_s, pend_hold_s, load_s, expire_s;
  logic             flash_ph_nx_s;
  logic [6:0]       lamps_r;
  logic [CNT_W-1:0] count_s;

  function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] st);
    case (st)
      S_MAIN_GREEN:  return CNT_W'(MAIN_GREEN_S);
      S_MAIN_YELLOW: return CNT_W'(YELLOW_S);
      S_ALL_RED_A:   return CNT_W'(ALL_RED_S);
      S_SIDE_GREEN:  return CNT_W'(SIDE_GREEN_S);
      S_SIDE_YELLOW: return CNT_W'(YELLOW_S);
      S_ALL_RED_B:   return CNT_W'(ALL_RED_S);
      S_PED_WALK:    return CNT_W'(WALK_S);
      default:       return CNT_W'(1);
    endcase
  endfunction

  tlc_phase_timer #(.CNT_W(CNT_W), .RST_VAL(MAIN_GREEN_S)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load_s),
    .load_val (phase_len(state_nx_s)),
    .count    (count_s),
    .expire   (expire_s)
  );

  // Phase sequencing; an unserviced MAIN_GREEN expiry holds with the timer at 1
  always_comb begin
    state_base_s = state_r;
    case (state_r)
      S_MAIN_GREEN:  if (expire_s && (side_pend_r || ped_pend_r)) state_base_s = S_MAIN_YELLOW;
                     else state_base_s = state_r;
      S_MAIN_YELLOW: if (expire_s) state_base_s = S_ALL_RED_A; else state_base_s = state_r;
      S_ALL_RED_A:   if (expire_s) state_base_s = side_pend_r ? S_SIDE_GREEN : S_PED_WALK;
                     else state_base_s = state_r;
      S_SIDE_GREEN:  if (expire_s) state_base_s = S_SIDE_YELLOW; else state_base_s = state_r;
      S_SIDE_YELLOW: if (expire_s) state_base_s = S_ALL_RED_B; else state_base_s = state_r;
      S_ALL_RED_B:   if (expire_s) state_base_s = ped_pend_r ? S_PED_WALK : S_MAIN_GREEN;
                     else state_base_s = state_r;
      S_PED_WALK:    if (expire_s) state_base_s = S_MAIN_GREEN; else state_base_s = state_r;
`ifdef TLC_FLASH_EN
      // FLASH exits into an all-red clearance before re-deciding on demand
      default:       state_base_s = S_ALL_RED_A;
`else
      default:       state_base_s = S_MAIN_GREEN;
`endif
    endcase
  end

`ifdef TLC_FLASH_EN
  logic flash_ph_r;

  // Flash override, blink phase (lit on entry, toggles per tick) and demand freeze
  always_comb begin
    state_nx_s  = flash ? S_FLASH : state_base_s;
    pend_hold_s = (state_nx_s == S_FLASH);
    if (state_nx_s == S_FLASH) begin
      if (state_r != S_FLASH) flash_ph_nx_s = 1'b1;
      else if (tick)          flash_ph_nx_s = ~flash_ph_r;
      else                    flash_ph_nx_s = flash_ph_r;
    end else begin
      flash_ph_nx_s = 1'b0;
    end
  end

  // Blink phase register
  always_ff @(posedge clk) begin
    if (rst) flash_ph_r <= 1'b0;
    else     flash_ph_r <= flash_ph_nx_s;
  end
`else
  assign state_nx_s    = state_base_s;
  assign pend_hold_s   = 1'b0;
  assign flash_ph_nx_s = 1'b0;
`endif

  assign load_s     = (state_nx_s != state_r);
  assign enter_sg_s = (state_nx_s == S_SIDE_GREEN) && (state_r != S_SIDE_GREEN);
  assign enter_pw_s = (state_nx_s == S_PED_WALK)   && (state_r != S_PED_WALK);

  // State, lamp and demand registers; clearing on service entry beats a new set
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_MAIN_GREEN;
      lamps_r     <= lamp_map(S_MAIN_GREEN, 1'b0);
      side_pend_r <= 1'b0;
      ped_pend_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      lamps_r <= lamp_map(state_nx_s, flash_ph_nx_s);
      if (pend_hold_s) begin
        side_pend_r <= side_pend_r;
        ped_pend_r  <= ped_pend_r;
      end else begin
        side_pend_r <= (side_pend_r | side_car) & ~enter_sg_s;
        ped_pend_r  <= (ped_pend_r  | ped_req)  & ~enter_pw_s;
      end
    end
  end

  assign main_light = lamps_r[6:4];
  assign side_light = lamps_r[3:1];
  assign walk       = lamps_r[0];
  assign state_code = state_r;
  assign time_left  = count_s;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: directed steps queue hand-computed
// outputs, a negedge monitor pops and compares them. Flash test under TLC_FLASH_EN.
module tb_traffic_light_fsm;

  localparam logic [2:0] MG = 3'd0, MY = 3'd1, ARA = 3'd2, SG = 3'd3,
                         SY = 3'd4, ARB = 3'd5, PW = 3'd6, FL = 3'd7;

  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, side_car = 1'b0, ped_req = 1'b0;
  logic       fy_tb = 1'b0;
`ifdef TLC_FLASH_EN
  logic       flash = 1'b0, flash_tb = 1'b0;
`endif
  logic [2:0] main_light, side_light, state_code;
  logic       walk;
  logic [7:0] time_left;

  traffic_light_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .side_car   (side_car),
    .ped_req    (ped_req),
`ifdef TLC_FLASH_EN
    .flash      (flash),
`endif
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .state_code (state_code),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [17:0] v;    // {state, time_left, main, side, walk}
    string       tag;
  } exp_t;

  exp_t  q[$];
  int    n_checks = 0, n_err = 0;
  string tag_s = "reset";

  function automatic logic [6:0] exp_lamps(input logic [2:0] st, input logic fy);
    case (st)
      3'd0:    return {3'b001, 3'b100, 1'b0};
      3'd1:    return {3'b010, 3'b100, 1'b0};
      3'd3:    return {3'b100, 3'b001, 1'b0};
      3'd4:    return {3'b100, 3'b010, 1'b0};
      3'd6:    return {3'b100, 3'b100, 1'b1};
      3'd7:    return fy ? {3'b010, 3'b010, 1'b0} : {3'b000, 3'b000, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  // One clock of stimulus; the expected outputs after that edge are queued.
  task automatic step(input logic r, input logic t, input logic s, input logic p,
                      input logic [2:0] st, input logic [7:0] tl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; tick = t; side_car = s; ped_req = p;
`ifdef TLC_FLASH_EN
    flash = flash_tb;
`endif
    e.due = cyc + 1;
    e.v   = {st, tl, exp_lamps(st, fy_tb)};
    e.tag = tag_s;
    q.push_back(e);
  endtask

  // A tick cycle followed by an idle cycle that must not change anything.
  task automatic tk(input logic [2:0] st, input logic [7:0] tl);
    step(1'b0, 1'b1, 1'b0, 1'b0, st, tl);
    step(1'b0, 1'b0, 1'b0, 1'b0, st, tl);
  endtask

  // Full phase of n ticks: the entering tick, then n-1 countdown ticks.
  task automatic enter(input logic [2:0] st, input int n);
    tk(st, 8'(n));
    for (int i = 1; i < n; i++) tk(st, 8'(n - i));
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] act;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      act = {state_code, time_left, main_light, side_light, walk};
      n_checks++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s cyc=%0d: got st=%0d tl=%0d main=%b side=%b walk=%b, want st=%0d tl=%0d main=%b side=%b walk=%b",
                 e.tag, cyc, act[17:15], act[14:7], act[6:4], act[3:1], act[0],
                 e.v[17:15], e.v[14:7], e.v[6:4], e.v[3:1], e.v[0]);
      end
    end
  end

  initial begin
    // Reset and idle hold: counts 10..1 then stays at 1
    tag_s = "reset";
    step(1'b1, 1'b0, 1'b0, 1'b0, MG, 8'd10);
    step(1'b0, 1'b0, 1'b0, 1'b0, MG, 8'd10);
    tag_s = "idle_hold";
    for (int i = 1; i <= 25; i++) tk(MG, (i < 10) ? 8'(10 - i) : 8'd1);

    // Side request pulsed before tick 3
    tag_s = "side_seq";
    step(1'b1, 1'b0, 1'b0, 1'b0, MG, 8'd10);
    tk(MG, 8'd9);
    tk(MG, 8'd8);
    step(1'b0, 1'b0, 1'b1, 1'b0, MG, 8'd8);
    for (int i = 3; i <= 9; i++) tk(MG, 8'(10 - i));
    enter(MY, 3); enter(ARA, 1); enter(SG, 6); enter(SY, 3); enter(ARB, 1);
    tk(MG, 8'd10);

    // Pedestrian request held only on tick 12 of the hold: seen on tick 13
    tag_s = "ped_seq";
    for (int i = 1; i <= 11; i++) tk(MG, (i < 10) ? 8'(10 - i) : 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, MG, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, MG, 8'd1);
    enter(MY, 3); enter(ARA, 1); enter(PW, 5);
    tk(MG, 8'd10);

    // Both requests; ped_req on the walk entry cycle is absorbed
    tag_s = "both_seq";
    step(1'b0, 1'b0, 1'b1, 1'b1, MG, 8'd10);
    for (int i = 1; i <= 9; i++) tk(MG, 8'(10 - i));
    enter(MY, 3); enter(ARA, 1); enter(SG, 6); enter(SY, 3); enter(ARB, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, PW, 8'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, PW, 8'd5);
    for (int i = 1; i <= 4; i++) tk(PW, 8'(5 - i));
    tk(MG, 8'd10);
    tag_s = "ped_absorbed";
    for (int i = 1; i <= 10; i++) tk(MG, (i < 10) ? 8'(10 - i) : 8'd1);

    // Reset with a coincident tick in the middle of SIDE_GREEN
    tag_s = "mid_reset";
    step(1'b0, 1'b0, 1'b1, 1'b1, MG, 8'd1);
    enter(MY, 3); enter(ARA, 1);
    tk(SG, 8'd6); tk(SG, 8'd5); tk(SG, 8'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, MG, 8'd10);
    step(1'b0, 1'b0, 1'b0, 1'b0, MG, 8'd10);
    tag_s = "pend_cleared";
    for (int i = 1; i <= 11; i++) tk(MG, (i < 10) ? 8'(10 - i) : 8'd1);

`ifdef TLC_FLASH_EN
    // Flash: yellow blinks per tick, pending side demand survives into ALL_RED_A
    tag_s = "flash";
    step(1'b0, 1'b0, 1'b1, 1'b0, MG, 8'd1);
    flash_tb = 1'b1; fy_tb = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, FL, 8'd1);
    fy_tb = 1'b0; tk(FL, 8'd1);
    fy_tb = 1'b1; tk(FL, 8'd1);
    fy_tb = 1'b0; tk(FL, 8'd1);
    fy_tb = 1'b1; tk(FL, 8'd1);
    flash_tb = 1'b0; fy_tb = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, ARA, 8'd1);
    tk(SG, 8'd6);
    tk(SG, 8'd5);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Four-way intersection controller. Sits directly downstream of the divider stage.
- Consumes a one-cycle 1 Hz enable pulse (`tick`) in the system clock domain. It does not use a divided clock as a clock.
- Sequences main/side vehicle lights and a pedestrian walk phase. Demand comes from latched side-road sensor and pedestrian button requests.
- All outputs are registered. They drive the lamp drivers and the seconds display.

Parameters:
- MAIN_GREEN_S, 10, minimum main green duration in ticks.
- SIDE_GREEN_S, 6, side green duration in ticks.
- YELLOW_S, 3, yellow duration in ticks, both roads.
- ALL_RED_S, 1, all-red clearance duration in ticks.
- WALK_S, 5, pedestrian walk duration in ticks.
- CNT_W, 8, width of the timer and of `time_left`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tick  in  1  one-cycle 1 Hz enable pulse from the divider stage
- side_car  in  1  side-road vehicle sensor, level or pulse
- ped_req  in  1  pedestrian button, level or pulse
- main_light  out  3  {red, yellow, green}, one-hot
- side_light  out  3  {red, yellow, green}, one-hot
- walk  out  1  pedestrian walk lamp
- state_code  out  3  current state encoding, for debug
- time_left  out  CNT_W  ticks remaining in current phase

Behaviour:
- States and lamps:
  - MAIN_GREEN (0): main 001, side 100
  - MAIN_YELLOW (1): main 010, side 100
  - ALL_RED_A (2): 100/100
  - SIDE_GREEN (3): main 100, side 001
  - SIDE_YELLOW (4): main 100, side 010
  - ALL_RED_B (5): 100/100
  - PED_WALK (6): 100/100, walk=1
  - `walk` is 0 in all other states.
- Reset, applied on a clk edge with rst=1:
  - state MAIN_GREEN, timer=MAIN_GREEN_S
  - main_light=001, side_light=100, walk=0, state_code=0, time_left=MAIN_GREEN_S
  - side_pend=0, ped_pend=0
  - rst overrides tick and requests in the same cycle. Reset mid-sequence returns to MAIN_GREEN immediately.
- Timer:
  - Loaded with the new state's duration on every state entry.
  - Each tick with timer>1 decrements it.
  - A tick with timer==1 expires the phase, except for the MAIN_GREEN hold rule below.
  - Each phase therefore lasts exactly N ticks.
  - Timer arithmetic is CNT_W unsigned. All durations must be ≥1 and <2^CNT_W; enforce with an elaboration-time check.
- Request latches:
  - side_pend is set whenever side_car=1, in any state.
  - ped_pend is set whenever ped_req=1, in any state.
  - side_pend is cleared on the cycle of entry into SIDE_GREEN; ped_pend on entry into PED_WALK.
  - If a set and a clear coincide, the clear wins.
- Transitions, all taken on an expiring tick:
  - MAIN_GREEN → MAIN_YELLOW if side_pend|ped_pend. Otherwise hold MAIN_GREEN with timer saturated at 1; leave on the first tick after a request latches.
  - MAIN_YELLOW → ALL_RED_A.
  - ALL_RED_A → SIDE_GREEN if side_pend, else PED_WALK.
  - SIDE_GREEN → SIDE_YELLOW.
  - SIDE_YELLOW → ALL_RED_B.
  - ALL_RED_B → PED_WALK if ped_pend, else MAIN_GREEN.
  - PED_WALK → MAIN_GREEN.
- Latency:
  - Outputs change on the clk edge that registers the expiring tick; no extra pipeline stage.
  - Requests are visible to the decision one cycle after assertion, through the latch.
- Invalid state encoding (7) recovers to MAIN_GREEN on the next clk.
- tick=0 freezes all timing. Requests still latch.

Optional Feature:
- Macro TLC_FLASH_EN, which adds input `flash` (1 bit).
- With the macro defined:
  - While flash=1, the FSM is forced to a FLASH state (code 7): main and side yellow toggle together on each tick, red/green are 0, walk=0, pendings are held.
  - Leaving the FLASH state when flash drops goes to ALL_RED_A, treated as expired after ALL_RED_S ticks and branching per pendings.
- Without the macro:
  - No `flash` port.
  - Code 7 is invalid and recovers as above.

Decomposition:
- Package tlc_pkg holds:
  - the state enum (3-bit, codes above)
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000
  - a function mapping state → {main_light, side_light, walk}
- One sub-module, tlc_phase_timer: a loadable CNT_W down-counter with tick enable and saturating hold. Outputs `expire` (tick & count==1) and `count`.

Test Plan:
- Reset, then 25 ticks with no requests → remain MAIN_GREEN, main=001, time_left counts 10..1 then holds 1.
- side_car pulse before tick 3 → after tick 10: MAIN_YELLOW for 3 ticks, ALL_RED_A for 1, SIDE_GREEN for 6, SIDE_YELLOW for 3, ALL_RED_B for 1, then MAIN_GREEN with time_left=10.
- ped_req only, held at tick 12 during hold → MAIN_YELLOW at tick 13, ALL_RED_A, then PED_WALK with walk=1 for 5 ticks, then MAIN_GREEN.
- side_car and ped_req both latched → full side sequence, then PED_WALK, then MAIN_GREEN. ped_req asserted on the PED_WALK entry cycle is absorbed (ped_pend=0 after).
- rst asserted for one cycle mid-SIDE_GREEN coincident with a tick → next cycle MAIN_GREEN, time_left=10, pendings 0.
- TLC_FLASH_EN defined, flash=1 for 4 ticks → main and side yellow toggle 010/000 each tick. After flash drops → ALL_RED_A for 1 tick, then a branch per pendings.
